// File: rtl/spi_pkg.sv
// Shared command codes and FSM state encoding for the byte-oriented SPI master.
package spi_pkg;

    localparam logic [1:0] CMD_SELECT   = 2'b00;
    localparam logic [1:0] CMD_DESELECT = 2'b01;
    localparam logic [1:0] CMD_XFER     = 2'b10;
    localparam logic [1:0] CMD_NOP      = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider and phase toggler: while enabled, toggles sclk every HALF_DIV cycles
// and flags the cycle before each toggle with a single-cycle rise_tick/fall_tick.
module spi_sclk_gen #(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap      = en && (cnt == CW'(HALF_DIV - 1));
    assign rise_tick = wrap && !sclk;
    assign fall_tick = wrap && sclk;

    // Disabling clears both counter and phase so every transfer starts from a known low phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_ctrl.sv
// Mode-0, MSB-first SPI master with explicit chip-select commands and 8-bit
// full-duplex transfers; ready is simply "FSM is idle".
module spi_ctrl
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic [7:0] rx_data,
    output logic       sclk,
    output logic       ss,
    input  logic       miso,
    output logic       mosi
);

    state_t     state;
    state_t     next_state;
    logic [7:0] shreg;
    logic [2:0] bitcnt;
    logic       rise_tick;
    logic       fall_tick;
    logic       last_fall;

    assign ready     = (state == ST_IDLE);
    assign last_fall = fall_tick && (bitcnt == 3'd0);

    spi_sclk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (state == ST_XFER),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Commands are only honoured in IDLE; a start during a transfer is dropped, not queued.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start && (cmd == CMD_XFER)) begin
                    next_state = ST_XFER;
                end
            end
            ST_XFER: begin
                if (last_fall) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss      <= 1'b1;
            mosi    <= 1'b0;
            shreg   <= 8'h00;
            bitcnt  <= 3'd0;
            rx_data <= 8'h00;
        end else if (state == ST_IDLE) begin
            if (start) begin
                case (cmd)
                    CMD_SELECT:   ss <= 1'b0;
                    CMD_DESELECT: ss <= 1'b1;
                    CMD_XFER: begin
                        shreg  <= data;
                        bitcnt <= 3'd7;
                        mosi   <= data[7];
                    end
                    default: ;
                endcase
            end
        end else begin
            // After a rise the next outgoing bit has already moved into shreg[7].
            if (rise_tick) begin
                shreg <= {shreg[6:0], miso};
            end
            if (fall_tick) begin
                if (bitcnt == 3'd0) begin
                    rx_data <= shreg;
                    mosi    <= 1'b0;
                end else begin
                    bitcnt  <= bitcnt - 3'd1;
                    mosi    <= shreg[7];
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_ctrl.sv
// Directed bench for spi_ctrl at HALF_DIV=2: inputs change and outputs are sampled on
// the falling system-clock edge, with expected values worked out by hand.
module tb_spi_ctrl;
    import spi_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] cmd;
    logic       start;
    logic [7:0] data;
    logic       ready;
    logic [7:0] rx_data;
    logic       sclk;
    logic       ss;
    logic       miso;
    logic       mosi;

    logic       loopback;
    logic       miso_tie;

    int checks;
    int errors;

    assign miso = loopback ? mosi : miso_tie;

    spi_ctrl #(
        .HALF_DIV (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd),
        .start   (start),
        .data    (data),
        .ready   (ready),
        .rx_data (rx_data),
        .sclk    (sclk),
        .ss      (ss),
        .miso    (miso),
        .mosi    (mosi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts at a falling edge, issues XFER, follows it to completion and checks
    // latency, rise count, the bits seen on mosi at each rise, ss and rx_data.
    task automatic run_xfer(input string name, input logic [7:0] tx,
                            input logic [7:0] exp_bits, input logic [7:0] exp_rx,
                            input logic exp_ss, input logic inject);
        logic [7:0] seen;
        logic       prev_sclk;
        logic       ss_bad;
        int         rises;
        int         done_at;
        seen    = 8'h00;
        rises   = 0;
        done_at = -1;
        ss_bad  = 1'b0;
        cmd   = CMD_XFER;
        data  = tx;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (ready !== 1'b0 || mosi !== tx[7] || sclk !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_accept: ready=%b mosi=%b sclk=%b, required ready=0 mosi=%b sclk=0",
                     name, ready, mosi, sclk, tx[7]);
        end
        prev_sclk = sclk;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                rises++;
                seen = {seen[6:0], mosi};
            end
            prev_sclk = sclk;
            if (ss !== exp_ss) ss_bad = 1'b1;
            if (inject) begin
                start = 1'b0;
                if (k == 5) begin
                    cmd   = CMD_DESELECT;
                    start = 1'b1;
                end else if (k == 13) begin
                    cmd   = CMD_XFER;
                    data  = 8'h00;
                    start = 1'b1;
                end else if (k == 21) begin
                    cmd   = CMD_SELECT;
                    start = 1'b1;
                end
            end
            if (ready === 1'b1) begin
                done_at = k;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (done_at != 32) begin
            errors++;
            $display("[TB] FAIL %s_busy: ready high after %0d cycles, required 32", name, done_at);
        end
        checks++;
        if (rises != 8) begin
            errors++;
            $display("[TB] FAIL %s_rises: got %0d sclk rises, required 8", name, rises);
        end
        checks++;
        if (seen !== exp_bits) begin
            errors++;
            $display("[TB] FAIL %s_mosi: bits at rises %b, required %b", name, seen, exp_bits);
        end
        checks++;
        if (rx_data !== exp_rx) begin
            errors++;
            $display("[TB] FAIL %s_rx: rx_data=%h, required %h", name, rx_data, exp_rx);
        end
        checks++;
        if (ss_bad || ss !== exp_ss) begin
            errors++;
            $display("[TB] FAIL %s_ss: ss left %b during transfer, now %b, required %b",
                     name, exp_ss, ss, exp_ss);
        end
        checks++;
        if (mosi !== 1'b0 || sclk !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle: mosi=%b sclk=%b, required 0 0", name, mosi, sclk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        cmd = CMD_NOP;
        data = 8'h00;
        loopback = 1'b0;
        miso_tie = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ss !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || ready !== 1'b1 || rx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset: ss=%b sclk=%b mosi=%b ready=%b rx=%h, required 1 0 0 1 00",
                     ss, sclk, mosi, ready, rx_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_select_xfer();
        loopback = 1'b1;
        cmd   = CMD_SELECT;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (ss !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL select: ss=%b ready=%b, required ss=0 ready=1", ss, ready);
        end
        run_xfer("xfer2e", 8'h2E, 8'b0010_1110, 8'h2E, 1'b0, 1'b0);
    endtask

    task automatic test_miso_high();
        loopback = 1'b0;
        miso_tie = 1'b1;
        run_xfer("xferca", 8'hCA, 8'b1100_1010, 8'hFF, 1'b0, 1'b0);
    endtask

    task automatic test_deselect();
        logic ready_drop;
        ready_drop = 1'b0;
        cmd   = CMD_DESELECT;
        start = 1'b1;
        if (ready !== 1'b1) ready_drop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (ready !== 1'b1) ready_drop = 1'b1;
        checks++;
        if (ss !== 1'b1) begin
            errors++;
            $display("[TB] FAIL deselect_ss: ss=%b, required 1", ss);
        end
        @(negedge clk);
        if (ready !== 1'b1) ready_drop = 1'b1;
        checks++;
        if (ready_drop) begin
            errors++;
            $display("[TB] FAIL deselect_ready: ready dropped, required steady 1");
        end
    endtask

    // Back-to-back transfers with ss high: the second is issued on the cycle ready is seen.
    task automatic test_back_to_back();
        miso_tie = 1'b0;
        run_xfer("b2b_a", 8'h81, 8'b1000_0001, 8'h00, 1'b1, 1'b0);
        loopback = 1'b1;
        run_xfer("b2b_b", 8'h96, 8'b1001_0110, 8'h96, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_start();
        loopback = 1'b1;
        cmd   = CMD_SELECT;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_xfer("ignore", 8'h3C, 8'b0011_1100, 8'h3C, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || sclk !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignore_queued: ready=%b sclk=%b, required 1 0", ready, sclk);
        end
    endtask

    task automatic test_reset_midxfer();
        loopback = 1'b0;
        miso_tie = 1'b1;
        cmd   = CMD_XFER;
        data  = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sclk !== 1'b1 || mosi !== 1'b1 || ready !== 1'b0 || ss !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midxfer_pre: sclk=%b mosi=%b ready=%b ss=%b, required 1 1 0 0",
                     sclk, mosi, ready, ss);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (ss !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || ready !== 1'b1 || rx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midxfer_reset: ss=%b sclk=%b mosi=%b ready=%b rx=%h, required 1 0 0 1 00",
                     ss, sclk, mosi, ready, rx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        loopback = 1'b1;
        cmd   = CMD_SELECT;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_xfer("after_rst", 8'h5A, 8'b0101_1010, 8'h5A, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_select_xfer();
        test_miso_high();
        test_deselect();
        test_back_to_back();
        test_ignore_start();
        test_reset_midxfer();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ctrl.md
# spi_ctrl

Byte-oriented SPI master (mode 0, MSB first) driven by a simple command/start handshake. It sits between a CPU-side peripheral register block and an external SPI device. It provides explicit chip-select control and full-duplex 8-bit transfers, with a `ready` flag to pace software.

## Interface
- `HALF_DIV`, default 2: system clocks per SCLK half-period; legal range ≥1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd`  in  2  command code: 00 SELECT, 01 DESELECT, 10 XFER, 11 NOP.
- `start`  in  1  one-cycle strobe; `cmd` and `data` are sampled on the same edge.
- `data`  in  8  transmit byte for XFER.
- `ready`  out  1  high when idle and able to accept a command.
- `rx_data`  out  8  last received byte; valid from the cycle `ready` rises after an XFER.
- `sclk`  out  1  SPI clock; idles low.
- `ss`  out  1  active-low slave select.
- `miso`  in  1  serial data from the slave.
- `mosi`  out  1  serial data to the slave.

## Operation
- Reset values: `sclk`=0, `ss`=1, `mosi`=0, `ready`=1, `rx_data`=0, state IDLE.
- States: IDLE and XFER. XFER has an internal phase (LOW/HIGH), a divider counter (0..HALF_DIV-1) and a bit counter (7..0).
- `start` is acted on only in IDLE. `start` in XFER is ignored, with no queuing.
- SELECT: `ss`←0 on the accepting edge. `ready` stays 1, so another command may follow on the very next cycle.
- DESELECT: `ss`←1 on the accepting edge. `ready` stays 1.
- NOP: no effect.
- XFER on the accepting edge:
  - `ready`←0; `mosi`←`data[7]`.
  - Load the shift register with `data`; bit counter←7; phase LOW; `sclk`=0.
  - Go to XFER.
- XFER performs no check of `ss`. The transfer runs even if `ss` is high; software is responsible for selecting first.
- In XFER, each HALF_DIV cycles toggles `sclk`:
  - Rising edge of `sclk`: sample `miso` into the shift register LSB, shifting left.
  - Falling edge of `sclk`, bits remaining: present the next bit on `mosi`.
  - Falling edge of the 8th bit: `rx_data`←shift register; `mosi`←0; `ready`←1; return to IDLE.
- `ss` is never changed by XFER.
- Reset mid-transfer aborts immediately to reset values, including `ss`=1.

## Timing
- SELECT/DESELECT: `ss` changes one edge after `start` is sampled. Zero busy cycles.
- XFER busy time is 16·HALF_DIV cycles. `ready` is low in the cycle after acceptance and high again 16·HALF_DIV edges after acceptance. With the default this is 32 cycles.
- First `sclk` rise occurs HALF_DIV cycles after acceptance; `sclk` period is 2·HALF_DIV cycles; exactly 8 rising edges per transfer.
- `mosi` is stable for at least HALF_DIV cycles before and after each `sclk` rise.
- Back-to-back XFER is possible: `start` may be accepted in the same cycle `ready` is observed high.

## Structure
- Shared package `spi_pkg`:
  - command localparams `CMD_SELECT`, `CMD_DESELECT`, `CMD_XFER`, `CMD_NOP`;
  - the state encoding (`ST_IDLE`, `ST_XFER`).
- One natural sub-module: `spi_sclk_gen`. It is the divider and phase toggler, emitting single-cycle `rise_tick`/`fall_tick` pulses while enabled.
- Shift register and FSM live in the top.

## Test plan
- Reset with `start` low → `ss`=1, `sclk`=0, `mosi`=0, `ready`=1, `rx_data`=0.
- SELECT then XFER `data`=0x2E on the next cycle, `miso` looped to `mosi` → `ss` falls, XFER accepted, bits 0,0,1,0,1,1,1,0 on `mosi` at 8 `sclk` rises, `ready` high after 32 cycles, `rx_data`=0x2E.
- Second XFER `data`=0xCA with `miso` tied 1 → `mosi` sequence 1,1,0,0,1,0,1,0, `rx_data`=0xFF, `ss` stays 0 throughout.
- DESELECT after the transfer → `ss`=1 one cycle later, `ready` never drops.
- `start` pulses (any `cmd`) during an XFER → ignored: `ss` unchanged, bit count and `rx_data` unaffected.
- Assert `rst` mid-XFER → outputs return to reset values immediately; the next XFER completes normally.
